// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Definitions shared by the router blocks: the per-channel transport retry
// stage, the judge and the direction logic.
//   DIR_NONE/DIR_X/DIR_Y/DIR_LOCAL : direction encodings (ROUTER_DIR_W wide)
//   retry_state_t                  : retry channel FSM states
//   clog2_min1()                   : $clog2 that never returns less than 1,
//                                    for sizing counters that can collapse
//                                    to a single value
// No ports.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_DIR_W = 2;

    localparam logic [ROUTER_DIR_W-1:0] DIR_NONE  = 2'b00;
    localparam logic [ROUTER_DIR_W-1:0] DIR_X     = 2'b01;
    localparam logic [ROUTER_DIR_W-1:0] DIR_Y     = 2'b10;
    localparam logic [ROUTER_DIR_W-1:0] DIR_LOCAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BACKOFF = 2'd2
    } retry_state_t;

    function automatic int clog2_min1(input int n);
        clog2_min1 = (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/transport_retry_ch.sv
// -----------------------------------------------------------------------------
// transport_retry_ch
// One channel of the transport retry stage. Issues a packet on o_dout, takes
// the judge verdict one cycle later and replays the packet on failure up to
// MAX_RETRY times, then drops it with a one-cycle o_drop pulse.
// Optional feature macro: TRANSPORT_RETRY_BACKOFF_EN -- inserts a NONE gap of
// (attempt index + 1) * BACKOFF_BASE cycles before each replay.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous reset, active-high
//   i_enable    global advance; 0 freezes the channel
//   i_dir       requested direction (!= NONE means valid)
//   i_data      payload
//   i_fail      judge verdict for the packet on o_dout in the previous cycle
//   o_ready     channel accepts i_dir/i_data this cycle (combinational)
//   o_dout      issued direction (registered)
//   o_dout_data issued payload (registered)
//   o_drop      one-cycle pulse when a packet is discarded
//   o_busy      channel is in WAIT or BACKOFF
// -----------------------------------------------------------------------------
module transport_retry_ch
    import router_pkg::*;
#(
    parameter int DIR_W        = 2,
    parameter int DATA_W       = 16,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF_BASE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [DIR_W-1:0]  i_dir,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_fail,
    output logic              o_ready,
    output logic [DIR_W-1:0]  o_dout,
    output logic [DATA_W-1:0] o_dout_data,
    output logic              o_drop,
    output logic              o_busy
);

    localparam int CNT_W = clog2_min1(MAX_RETRY + 1);
    // Largest backoff load is MAX_RETRY*BACKOFF_BASE-1.
    localparam int BO_W  = clog2_min1(MAX_RETRY * BACKOFF_BASE);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RETRY);
    localparam logic [DIR_W-1:0] NONE    = DIR_W'(DIR_NONE);

    retry_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BO_W-1:0]   r_bo;
    logic [DIR_W-1:0]  r_hold_dir;
    logic [DIR_W-1:0]  r_dout;
    logic [DATA_W-1:0] r_data;
    logic              r_drop;

    logic w_ready;
    logic w_accept;

    // A passing verdict frees the channel in the same cycle, so a new packet
    // can follow back-to-back; this makes fail -> ready combinational.
    assign w_ready  = i_enable & ((r_state == IDLE) | ((r_state == WAIT) & ~i_fail));
    assign w_accept = w_ready & (i_dir != NONE);

`ifdef TRANSPORT_RETRY_BACKOFF_EN
    logic [BO_W-1:0] w_bo_load;
    // Gap grows with the attempt index: (cnt+1)*BASE cycles of NONE,
    // loaded as a count-down ending at 0.
    assign w_bo_load = BO_W'((32'(r_cnt) + 32'd1) * 32'(BACKOFF_BASE) - 32'd1);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bo       <= '0;
            r_hold_dir <= NONE;
            r_dout     <= NONE;
            r_data     <= '0;
            r_drop     <= 1'b0;
        end else begin
            // drop is a pulse; it also clears while frozen.
            r_drop <= 1'b0;
            if (i_enable) begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_state    <= WAIT;
                            r_cnt      <= '0;
                            r_hold_dir <= i_dir;
                            r_dout     <= i_dir;
                            r_data     <= i_data;
                        end else begin
                            r_dout <= NONE;
                        end
                    end
                    WAIT: begin
                        if (!i_fail) begin
                            if (w_accept) begin
                                r_cnt      <= '0;
                                r_hold_dir <= i_dir;
                                r_dout     <= i_dir;
                                r_data     <= i_data;
                            end else begin
                                r_state <= IDLE;
                                r_dout  <= NONE;
                            end
                        end else if (r_cnt == CNT_MAX) begin
                            r_state <= IDLE;
                            r_dout  <= NONE;
                            r_drop  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
`ifdef TRANSPORT_RETRY_BACKOFF_EN
                            r_state <= BACKOFF;
                            r_dout  <= NONE;
                            r_bo    <= w_bo_load;
`endif
                            // Without backoff, dout/dout_data simply hold,
                            // which re-drives the packet next cycle.
                        end
                    end
                    BACKOFF: begin
                        // Only reachable with backoff enabled.
                        if (r_bo == '0) begin
                            r_state <= WAIT;
                            r_dout  <= r_hold_dir;
                        end else begin
                            r_bo <= r_bo - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_dout  <= NONE;
                    end
                endcase
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_dout      = r_dout;
    assign o_dout_data = r_data;
    assign o_drop      = r_drop;
    assign o_busy      = (r_state == WAIT) | (r_state == BACKOFF);

endmodule

// File: rtl/transport_retry.sv
// -----------------------------------------------------------------------------
// transport_retry
// Per-output-channel retry stage between the direction logic and the judge.
// N_CH independent channels; channel i uses slice [i*DIR_W +: DIR_W] of the
// direction buses and [i*DATA_W +: DATA_W] of the payload buses
// (ch N_CH-1 = X ... ch0 = LOCAL by default).
// Optional feature macro: TRANSPORT_RETRY_BACKOFF_EN (see transport_retry_ch).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-high despite the name
//   enable     global advance; 0 freezes all state and outputs
//   in_dir     requested direction per channel
//   in_data    payload per channel
//   in_ready   per-channel accept (combinational from fail)
//   fail       per-channel judge verdict for last cycle's dout
//   dout       issued direction per channel (registered)
//   dout_data  issued payload per channel (registered)
//   drop       per-channel one-cycle discard pulse
//   busy       per-channel WAIT/BACKOFF indication
// -----------------------------------------------------------------------------
module transport_retry #(
    parameter int N_CH         = 3,
    parameter int DIR_W        = 2,
    parameter int DATA_W       = 16,
    parameter int MAX_RETRY    = 3,
    parameter int BACKOFF_BASE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N_CH*DIR_W-1:0]    in_dir,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH-1:0]          fail,
    output logic [N_CH*DIR_W-1:0]    dout,
    output logic [N_CH*DATA_W-1:0]   dout_data,
    output logic [N_CH-1:0]          drop,
    output logic [N_CH-1:0]          busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        transport_retry_ch #(
            .DIR_W        (DIR_W),
            .DATA_W       (DATA_W),
            .MAX_RETRY    (MAX_RETRY),
            .BACKOFF_BASE (BACKOFF_BASE)
        ) u_ch (
            .i_clk       (clk),
            .i_rst       (rst_n),
            .i_enable    (enable),
            .i_dir       (in_dir[i*DIR_W +: DIR_W]),
            .i_data      (in_data[i*DATA_W +: DATA_W]),
            .i_fail      (fail[i]),
            .o_ready     (in_ready[i]),
            .o_dout      (dout[i*DIR_W +: DIR_W]),
            .o_dout_data (dout_data[i*DATA_W +: DATA_W]),
            .o_drop      (drop[i]),
            .o_busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_transport_retry.sv
// -----------------------------------------------------------------------------
// tb_transport_retry
// Directed bench for transport_retry. Two instances share the stimulus:
// dut3 (MAX_RETRY=3) and dut0 (MAX_RETRY=0). Backoff scenarios are built
// when TRANSPORT_RETRY_BACKOFF_EN is defined, immediate-replay ones otherwise.
// -----------------------------------------------------------------------------
module tb_transport_retry;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [5:0]  in_dir;
    logic [47:0] in_data;
    logic [2:0]  fail;

    logic [2:0]  rdy3, drop3, busy3;
    logic [5:0]  dout3;
    logic [47:0] data3;
    logic [2:0]  rdy0, drop0, busy0;
    logic [5:0]  dout0;
    logic [47:0] data0;

    int checks = 0;
    int errors = 0;

    transport_retry #(.N_CH(3), .DIR_W(2), .DATA_W(16), .MAX_RETRY(3), .BACKOFF_BASE(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_dir(in_dir), .in_data(in_data),
        .in_ready(rdy3), .fail(fail), .dout(dout3), .dout_data(data3), .drop(drop3), .busy(busy3)
    );

    transport_retry #(.N_CH(3), .DIR_W(2), .DATA_W(16), .MAX_RETRY(0), .BACKOFF_BASE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_dir(in_dir), .in_data(in_data),
        .in_ready(rdy0), .fail(fail), .dout(dout0), .dout_data(data0), .drop(drop0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        in_dir = '0;
        fail   = '0;
        enable = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b1; enable = 1'b1; in_dir = '0; in_data = '0; fail = '0;
        tick(); tick();
        checks++; if (dout3 !== 6'b0) begin errors++; $display("FAIL reset_dout got %b exp %b", dout3, 6'b0); end
        checks++; if (data3 !== 48'b0) begin errors++; $display("FAIL reset_data got %h exp %h", data3, 48'b0); end
        checks++; if (drop3 !== 3'b0 || busy3 !== 3'b0) begin errors++; $display("FAIL reset_drop_busy got %b/%b exp 000/000", drop3, busy3); end
        checks++; if (rdy3 !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", rdy3); end
        rst_n = 1'b0;
        in_dir[5:4] = 2'b01; in_data[47:32] = 16'h1111;
        tick();
        checks++; if (dout3[5:4] !== 2'b01 || busy3[2] !== 1'b1) begin errors++; $display("FAIL reset_pre_wait got %b/%b exp 01/1", dout3[5:4], busy3[2]); end
        in_dir = '0;
        #2 rst_n = 1'b1;
        #1;
        checks++; if (dout3 !== 6'b0 || busy3 !== 3'b0) begin errors++; $display("FAIL reset_async got %b/%b exp 0/0", dout3, busy3); end
        checks++; if (drop3 !== 3'b0) begin errors++; $display("FAIL reset_async_drop got %b exp 000", drop3); end
        tick();
        checks++; if (drop3 !== 3'b0 || dout3 !== 6'b0) begin errors++; $display("FAIL reset_hold got %b/%b exp 0/0", drop3, dout3); end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_streaming;
        for (int k = 0; k < 4; k++) begin
            in_dir[5:4] = 2'b01;
            in_data[47:32] = 16'h1000 + 16'(k);
            #1;
            checks++; if (rdy3[2] !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", k, rdy3[2]); end
            tick();
            checks++; if (dout3[5:4] !== 2'b01 || data3[47:32] !== 16'h1000 + 16'(k)) begin
                errors++; $display("FAIL stream_out%0d got %b/%h exp 01/%h", k, dout3[5:4], data3[47:32], 16'h1000 + 16'(k)); end
            checks++; if (drop3 !== 3'b0) begin errors++; $display("FAIL stream_drop%0d got %b exp 000", k, drop3); end
        end
        in_dir = '0;
        tick();
        checks++; if (dout3[5:4] !== 2'b00 || busy3[2] !== 1'b0) begin errors++; $display("FAIL stream_end got %b/%b exp 00/0", dout3[5:4], busy3[2]); end
        settle();
    endtask

`ifndef TRANSPORT_RETRY_BACKOFF_EN
    task automatic test_single_retry;
        in_dir[3:2] = 2'b10; in_data[31:16] = 16'hA5A5;
        tick();
        checks++; if (dout3[3:2] !== 2'b10 || data3[31:16] !== 16'hA5A5) begin errors++; $display("FAIL retry_first got %b/%h exp 10/a5a5", dout3[3:2], data3[31:16]); end
        in_dir = '0; fail[1] = 1'b1;
        #1;
        checks++; if (rdy3[1] !== 1'b0) begin errors++; $display("FAIL retry_ready got %b exp 0", rdy3[1]); end
        tick();
        checks++; if (dout3[3:2] !== 2'b10 || data3[31:16] !== 16'hA5A5 || busy3[1] !== 1'b1) begin
            errors++; $display("FAIL retry_replay got %b/%h/%b exp 10/a5a5/1", dout3[3:2], data3[31:16], busy3[1]); end
        fail = '0;
        tick();
        checks++; if (dout3[3:2] !== 2'b00 || data3[31:16] !== 16'hA5A5 || busy3[1] !== 1'b0 || drop3 !== 3'b0) begin
            errors++; $display("FAIL retry_done got %b/%h/%b/%b exp 00/a5a5/0/000", dout3[3:2], data3[31:16], busy3[1], drop3); end
        settle();
    endtask

    task automatic test_exhaustion;
        in_dir[1:0] = 2'b11; in_data[15:0] = 16'h1234;
        tick();
        in_dir = '0; fail[0] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            checks++; if (dout3[1:0] !== 2'b11 || drop3[0] !== 1'b0) begin
                errors++; $display("FAIL exhaust_attempt%0d got %b/%b exp 11/0", a + 1, dout3[1:0], drop3[0]); end
            tick();
        end
        checks++; if (dout3[1:0] !== 2'b00 || drop3[0] !== 1'b1 || busy3[0] !== 1'b0) begin
            errors++; $display("FAIL exhaust_drop got %b/%b/%b exp 00/1/0", dout3[1:0], drop3[0], busy3[0]); end
        tick();
        checks++; if (dout3[1:0] !== 2'b00 || drop3[0] !== 1'b0) begin errors++; $display("FAIL exhaust_pulse got %b/%b exp 00/0", dout3[1:0], drop3[0]); end
        settle();
    endtask
`endif

    task automatic test_max_retry0;
        in_dir[1:0] = 2'b11; in_data[15:0] = 16'hBEEF;
        tick();
        checks++; if (dout0[1:0] !== 2'b11 || data0[15:0] !== 16'hBEEF) begin errors++; $display("FAIL mr0_issue got %b/%h exp 11/beef", dout0[1:0], data0[15:0]); end
        in_dir = '0; fail[0] = 1'b1;
        tick();
        checks++; if (dout0[1:0] !== 2'b00 || drop0[0] !== 1'b1 || busy0[0] !== 1'b0) begin
            errors++; $display("FAIL mr0_drop got %b/%b/%b exp 00/1/0", dout0[1:0], drop0[0], busy0[0]); end
        fail = '0;
        tick();
        checks++; if (drop0[0] !== 1'b0) begin errors++; $display("FAIL mr0_pulse got %b exp 0", drop0[0]); end
        settle();
    endtask

    task automatic test_enable_freeze;
        in_dir[5:4] = 2'b01; in_data[47:32] = 16'h0077;
        tick();
        checks++; if (dout3[5:4] !== 2'b01) begin errors++; $display("FAIL freeze_issue got %b exp 01", dout3[5:4]); end
        in_dir = '0; enable = 1'b0; fail[2] = 1'b1;
        #1;
        checks++; if (rdy3 !== 3'b000) begin errors++; $display("FAIL freeze_ready got %b exp 000", rdy3); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (dout3[5:4] !== 2'b01 || busy3[2] !== 1'b1 || data3[47:32] !== 16'h0077) begin
                errors++; $display("FAIL freeze_hold%0d got %b/%b/%h exp 01/1/0077", k, dout3[5:4], busy3[2], data3[47:32]); end
        end
        enable = 1'b1; fail = '0;
        tick();
        checks++; if (dout3[5:4] !== 2'b00 || busy3[2] !== 1'b0) begin errors++; $display("FAIL freeze_release got %b/%b exp 00/0", dout3[5:4], busy3[2]); end
        settle();
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_ch1;
        in_dir[5:4] = 2'b01; in_data[47:32] = 16'h2001;
        in_dir[3:2] = 2'b10; in_data[31:16] = 16'h3001;
        tick();
        checks++; if (dout3[5:2] !== 4'b0110) begin errors++; $display("FAIL b2b_first got %b exp 0110", dout3[5:2]); end
        in_dir[5:4] = 2'b01; in_data[47:32] = 16'h2002;
        in_dir[3:2] = 2'b00; fail[1] = 1'b1;
        #1;
        checks++; if (rdy3[2:1] !== 2'b10) begin errors++; $display("FAIL b2b_ready got %b exp 10", rdy3[2:1]); end
        tick();
`ifdef TRANSPORT_RETRY_BACKOFF_EN
        exp_ch1 = 2'b00;
`else
        exp_ch1 = 2'b10;
`endif
        checks++; if (dout3[5:4] !== 2'b01 || data3[47:32] !== 16'h2002) begin errors++; $display("FAIL b2b_ch2 got %b/%h exp 01/2002", dout3[5:4], data3[47:32]); end
        checks++; if (dout3[3:2] !== exp_ch1 || data3[31:16] !== 16'h3001) begin errors++; $display("FAIL b2b_ch1 got %b/%h exp %b/3001", dout3[3:2], data3[31:16], exp_ch1); end
        settle();
    endtask

`ifdef TRANSPORT_RETRY_BACKOFF_EN
    task automatic test_backoff;
        int gap;
        in_dir[3:2] = 2'b10; in_data[31:16] = 16'hA5A5;
        tick();
        in_dir = '0;
        checks++; if (dout3[3:2] !== 2'b10) begin errors++; $display("FAIL bo_first got %b exp 10", dout3[3:2]); end
        fail[1] = 1'b1;
        tick();
        fail = '0;
        gap = 0;
        for (int k = 0; k < 20 && dout3[3:2] === 2'b00; k++) begin gap++; tick(); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL bo_gap1 got %0d exp 2", gap); end
        checks++; if (dout3[3:2] !== 2'b10 || data3[31:16] !== 16'hA5A5) begin errors++; $display("FAIL bo_replay1 got %b/%h exp 10/a5a5", dout3[3:2], data3[31:16]); end
        fail[1] = 1'b1;
        tick();
        fail = '0;
        checks++; if (busy3[1] !== 1'b1 || rdy3[1] !== 1'b0 || dout3[3:2] !== 2'b00) begin
            errors++; $display("FAIL bo_state got %b/%b/%b exp 1/0/00", busy3[1], rdy3[1], dout3[3:2]); end
        gap = 1;
        enable = 1'b0;
        repeat (2) begin tick(); if (dout3[3:2] === 2'b00) gap++; end
        enable = 1'b1;
        for (int k = 0; k < 20 && dout3[3:2] === 2'b00; k++) begin tick(); if (dout3[3:2] === 2'b00) gap++; end
        checks++; if (gap !== 6) begin errors++; $display("FAIL bo_gap2_stretched got %0d exp 6", gap); end
        checks++; if (dout3[3:2] !== 2'b10 || drop3[1] !== 1'b0) begin errors++; $display("FAIL bo_replay2 got %b/%b exp 10/0", dout3[3:2], drop3[1]); end
        tick();
        checks++; if (dout3[3:2] !== 2'b00 || busy3[1] !== 1'b0) begin errors++; $display("FAIL bo_done got %b/%b exp 00/0", dout3[3:2], busy3[1]); end
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
`ifndef TRANSPORT_RETRY_BACKOFF_EN
        test_single_retry();
        test_exhaustion();
`else
        test_backoff();
`endif
        test_max_retry0();
        test_enable_freeze();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
